// File: rtl/kv260_led_pkg.sv
// rtl/kv260_led_pkg.sv - shared LED mode constants, button FSM states and helpers
package kv260_led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b01;
    localparam logic [1:0] MODE_COUNTER = 2'b10;
    localparam logic [1:0] MODE_KNIGHT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    // Saturating increment for the 32-bit debounce and hold counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer plus counter debouncer for one button
module btn_debounce
    import kv260_led_pkg::*;
#(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [31:0] DEB_LAST = (DEB_CYCLES > 0) ? 32'(DEB_CYCLES - 1) : 32'd0;

    logic        sync1;
    logic        sync2;
    logic [31:0] cnt;

    // Two-stage synchronizer for the asynchronous raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept the synchronized level only after it has differed from btn_db for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 1'b0;
            cnt    <= 32'd0;
        end else if (sync2 == btn_db) begin
            cnt <= 32'd0;
        end else if (cnt == DEB_LAST) begin
            btn_db <= sync2;
            cnt    <= 32'd0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/btn_mode_ctrl.sv
// rtl/btn_mode_ctrl.sv - two-button LED mode selector with NEXT long-press to OFF
module btn_mode_ctrl
    import kv260_led_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn_raw,
    output logic [1:0] mode,
    output logic       mode_chg,
    output logic [1:0] btn_db,
    output logic [3:0] dbg_state
);

    localparam int          DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int          LONG_CYCLES = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam logic [31:0] LONG_LAST   = (LONG_CYCLES > 0) ? 32'(LONG_CYCLES - 1) : 32'd0;

    btn_state_t  state;
    btn_state_t  state_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] hold_nxt;
    logic [1:0]  db_q;
    logic [1:0]  mode_nxt;
    logic        long_force;
    logic        short_inc;
    logic        next_rise;
    logic        next_fall;
    logic        prev_fall;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .btn_db (btn_db[i])
        );
    end

    assign next_rise = btn_db[0] & ~db_q[0];
    assign next_fall = ~btn_db[0] & db_q[0];
    assign prev_fall = ~btn_db[1] & db_q[1];
    assign dbg_state = {2'b00, state};

    // Delayed debounced levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= 2'b00;
        end else begin
            db_q <= btn_db;
        end
    end

    // NEXT-button FSM state and hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= 32'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // NEXT-button FSM: short release steps the mode, reaching the hold limit forces OFF
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        long_force = 1'b0;
        short_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (next_rise) begin
                    state_nxt = ST_PRESSED;
                    hold_nxt  = 32'd0;
                end
            end
            ST_PRESSED: begin
                if (hold_cnt == LONG_LAST) begin
                    // A release landing on the limit cycle is consumed here so LONG is not left waiting
                    long_force = 1'b1;
                    state_nxt  = next_fall ? ST_IDLE : ST_LONG;
                end else if (next_fall) begin
                    short_inc = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    hold_nxt = sat_inc(hold_cnt);
                end
            end
            ST_LONG: begin
                if (next_fall) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next mode: long press wins, simultaneous NEXT/PREV steps cancel
    always_comb begin
        mode_nxt = mode;
        if (long_force) begin
            mode_nxt = MODE_OFF;
        end else if (short_inc && !prev_fall) begin
            mode_nxt = (mode == MODE_KNIGHT) ? MODE_OFF : mode + 2'd1;
        end else if (prev_fall && !short_inc) begin
            mode_nxt = (mode == MODE_OFF) ? MODE_KNIGHT : mode - 2'd1;
        end
    end

    // Registered mode with a change pulse coincident with the new value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= MODE_OFF;
            mode_chg <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            mode_chg <= (mode_nxt != mode);
        end
    end

endmodule
